// File: rtl/rf_riscv_mp.sv
// -----------------------------------------------------------------------------
// rf_riscv_mp
//   Multi-read-port architectural register file with a per-register busy
//   scoreboard and a sequential clear engine.
//
//   A clear request starts a sweep that zeroes one register (data and busy)
//   per cycle. While the sweep runs, writes, reserves and further clear
//   requests are dropped, but reads stay live. With ZERO_REG=1, register 0
//   always reads as zero, is never busy, and is skipped by the sweep.
//
// Ports:
//   clk_i, rst_ni                 clock, asynchronous active-low reset
//   write_enable_i/addr_i/data_i  single synchronous write port
//   read_addr_i                   RD_PORTS packed read addresses
//   read_data_o, read_busy_o      combinational read data and busy bits
//   reserve_i, reserve_addr_i     mark one register pending per cycle
//   clear_i                       request a clear sweep
//   clear_busy_o                  high while the sweep runs
//
// Optional build macro:
//   RF_BYPASS_EN  forward an accepted write to any read port addressing the
//                 same register in the same cycle. Busy then shows the
//                 post-edge value.
// -----------------------------------------------------------------------------
module rf_riscv_mp #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int RD_PORTS = 2,
  parameter int ZERO_REG = 1
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       write_enable_i,
  input  logic [ADDR_W-1:0]          write_addr_i,
  input  logic [DATA_W-1:0]          write_data_i,
  input  logic [RD_PORTS*ADDR_W-1:0] read_addr_i,
  output logic [RD_PORTS*DATA_W-1:0] read_data_o,
  output logic [RD_PORTS-1:0]        read_busy_o,
  input  logic                       reserve_i,
  input  logic [ADDR_W-1:0]          reserve_addr_i,
  input  logic                       clear_i,
  output logic                       clear_busy_o
);

  localparam int              DEPTH      = 2**ADDR_W;
  localparam bit              HAS_ZERO   = (ZERO_REG != 0);
  localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(DEPTH-1);
  localparam logic [ADDR_W-1:0] FIRST_ADDR = HAS_ZERO ? ADDR_W'(1) : '0;

  typedef enum logic {IDLE, SWEEP} state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   cnt_q, cnt_d;
  logic [DATA_W-1:0]   mem_q [DEPTH];
  logic [DEPTH-1:0]    busy_q;
  logic                wr_ok;
  logic                rsv_ok;

  // Writes and reserves are only honoured outside the sweep; register 0 is
  // filtered here so it never gets data or a busy bit.
  assign wr_ok  = (state_q == IDLE) && write_enable_i &&
                  !(HAS_ZERO && (write_addr_i == '0));
  assign rsv_ok = (state_q == IDLE) && reserve_i &&
                  !(HAS_ZERO && (reserve_addr_i == '0));

  assign clear_busy_o = (state_q == SWEEP);

  // ---------------------------------------------------------------------------
  // Sweep FSM
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every output of this block gets a default before the case, so no
    // path leaves a signal unassigned and no latch is inferred.
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (clear_i) begin
          state_d = SWEEP;
          cnt_d   = FIRST_ADDR;
        end
      end
      SWEEP: begin
        // Leave after clearing the last register so the counter never wraps.
        if (cnt_q == LAST_ADDR) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Storage and scoreboard
  // ---------------------------------------------------------------------------
  // NOTE: the whole array is reset (not just control) because reads must never
  // return X, including mid-sweep and right after reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      busy_q <= '0;
    end else if (state_q == SWEEP) begin
      mem_q[cnt_q]  <= '0;
      busy_q[cnt_q] <= 1'b0;
    end else begin
      if (wr_ok) begin
        mem_q[write_addr_i]  <= write_data_i;
        busy_q[write_addr_i] <= 1'b0;
      end
      // Placed after the write so a same-address reservation wins.
      if (rsv_ok) busy_q[reserve_addr_i] <= 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Read ports
  // ---------------------------------------------------------------------------
  for (genvar k = 0; k < RD_PORTS; k++) begin : g_rd
    logic [ADDR_W-1:0] ra;
    logic [DATA_W-1:0] stored_data;
    logic              stored_busy;

    assign ra          = read_addr_i[k*ADDR_W +: ADDR_W];
    // mem_q[0] is never written when HAS_ZERO; the mask lets synthesis drop it.
    assign stored_data = (HAS_ZERO && (ra == '0)) ? '0 : mem_q[ra];
    assign stored_busy = busy_q[ra];

`ifdef RF_BYPASS_EN
    logic hit;
    assign hit = wr_ok && (write_addr_i == ra);
    assign read_data_o[k*DATA_W +: DATA_W] = hit ? write_data_i : stored_data;
    assign read_busy_o[k] = hit ? (rsv_ok && (reserve_addr_i == ra)) : stored_busy;
`else
    assign read_data_o[k*DATA_W +: DATA_W] = stored_data;
    assign read_busy_o[k]                  = stored_busy;
`endif
  end

endmodule

// File: tb/tb_rf_riscv_mp.sv
// -----------------------------------------------------------------------------
// tb_rf_riscv_mp
//   Self-checking bench for rf_riscv_mp. The default instance (2 ports,
//   register 0 hardwired) is compared every cycle against a behavioural model
//   built from arrays and a queue of pending sweep addresses. A second
//   instance (4 ports, ordinary register 0) is checked with directed literal
//   expectations. Directed literal checks also pin the model itself.
// -----------------------------------------------------------------------------
module tb_rf_riscv_mp;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NP = 2;

  logic clk_i  = 1'b0;
  logic rst_ni = 1'b0;

  always #5 clk_i = ~clk_i;

  // Main instance
  logic               we = 1'b0;
  logic [AW-1:0]      wa = '0;
  logic [DW-1:0]      wd = '0;
  logic [NP*AW-1:0]   raddr = '0;
  logic [NP*DW-1:0]   rdata;
  logic [NP-1:0]      rbusy;
  logic               rsv = 1'b0;
  logic [AW-1:0]      rsv_a = '0;
  logic               clr = 1'b0;
  logic               cbusy;

  rf_riscv_mp #(.DATA_W(DW), .ADDR_W(AW), .RD_PORTS(NP), .ZERO_REG(1)) dut (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .write_enable_i (we),
    .write_addr_i   (wa),
    .write_data_i   (wd),
    .read_addr_i    (raddr),
    .read_data_o    (rdata),
    .read_busy_o    (rbusy),
    .reserve_i      (rsv),
    .reserve_addr_i (rsv_a),
    .clear_i        (clr),
    .clear_busy_o   (cbusy)
  );

  // Four-port instance with an ordinary register 0
  logic               we4 = 1'b0;
  logic [AW-1:0]      wa4 = '0;
  logic [DW-1:0]      wd4 = '0;
  logic [4*AW-1:0]    raddr4 = '0;
  logic [4*DW-1:0]    rdata4;
  logic [3:0]         rbusy4;
  logic               rsv4 = 1'b0;
  logic [AW-1:0]      rsv_a4 = '0;
  logic               clr4 = 1'b0;
  logic               cbusy4;

  rf_riscv_mp #(.DATA_W(DW), .ADDR_W(AW), .RD_PORTS(4), .ZERO_REG(0)) dut4 (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .write_enable_i (we4),
    .write_addr_i   (wa4),
    .write_data_i   (wd4),
    .read_addr_i    (raddr4),
    .read_data_o    (rdata4),
    .read_busy_o    (rbusy4),
    .reserve_i      (rsv4),
    .reserve_addr_i (rsv_a4),
    .clear_i        (clr4),
    .clear_busy_o   (cbusy4)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Behavioural model of the main instance
  // ---------------------------------------------------------------------------
  logic [DW-1:0] m_mem  [32];
  bit            m_busy [32];
  int            sweep_q[$];   // registers still waiting to be zeroed

  always @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < 32; i++) begin
        m_mem[i]  = '0;
        m_busy[i] = 1'b0;
      end
      sweep_q.delete();
    end else if (sweep_q.size() != 0) begin
      int a;
      a = sweep_q.pop_front();
      m_mem[a]  = '0;
      m_busy[a] = 1'b0;
    end else begin
      if (we && wa != 0) begin
        m_mem[wa]  = wd;
        m_busy[wa] = 1'b0;
      end
      if (rsv && rsv_a != 0) m_busy[rsv_a] = 1'b1;
      if (clr) for (int a = 1; a < 32; a++) sweep_q.push_back(a);
    end
  end

  function automatic logic [DW-1:0] exp_data(input int a);
    logic [DW-1:0] v;
    v = (a == 0) ? '0 : m_mem[a];
`ifdef RF_BYPASS_EN
    if (sweep_q.size() == 0 && we && wa != 0 && int'(wa) == a) v = wd;
`endif
    return v;
  endfunction

  function automatic logic exp_busy(input int a);
    logic b;
    b = (a == 0) ? 1'b0 : m_busy[a];
`ifdef RF_BYPASS_EN
    if (sweep_q.size() == 0 && we && wa != 0 && int'(wa) == a)
      b = rsv && (rsv_a == wa);
`endif
    return b;
  endfunction

  // One compare process: outputs checked on the falling edge of every cycle.
  bit chk_en = 1'b0;
  always @(negedge clk_i) begin
    if (chk_en) begin
      for (int k = 0; k < NP; k++) begin
        int a;
        a = int'(raddr[k*AW +: AW]);
        check($sformatf("model rd_data[%0d] r%0d", k, a), 64'(rdata[k*DW +: DW]), 64'(exp_data(a)));
        check($sformatf("model rd_busy[%0d] r%0d", k, a), 64'(rbusy[k]), 64'(exp_busy(a)));
      end
      check("model clear_busy", 64'(cbusy), 64'(sweep_q.size() != 0));
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------------
  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle();
    we  = 1'b0;
    rsv = 1'b0;
    clr = 1'b0;
  endtask

  task automatic set_rd(input logic [AW-1:0] p0, input logic [AW-1:0] p1);
    raddr = {p1, p0};
  endtask

  function automatic logic [DW-1:0] rd(input int k);
    return rdata[k*DW +: DW];
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int cnt;

    // ---- Reset state ----
    set_rd(5, 3);
    repeat (2) @(posedge clk_i);
    #1;
    chk_en = 1'b1;
    check("reset rd0", 64'(rd(0)), 64'h0);
    check("reset busy", 64'(rbusy), 64'h0);
    check("reset clear_busy", 64'(cbusy), 64'h0);
    rst_ni = 1'b1;

    // ---- Test 1: write r5, dropped write to r0 ----
    set_rd(5, 0);
    we = 1'b1; wa = 5'd5; wd = 32'hDEADBEEF;
    step();
    wa = 5'd0; wd = 32'h1234;
    step();
    idle();
    #1;
    check("t1 r5", 64'(rd(0)), 64'hDEADBEEF);
    check("t1 r0", 64'(rd(1)), 64'h0);

    // ---- Test 2: reserve / write interplay on r7 ----
    rsv = 1'b1; rsv_a = 5'd7;
    step();
    idle();
    set_rd(7, 7);
    #1;
    check("t2 busy after reserve", 64'(rbusy[0]), 64'h1);
    we = 1'b1; wa = 5'd7; wd = 32'h55;
    step();
    idle();
    #1;
    check("t2 busy after write", 64'(rbusy[0]), 64'h0);
    check("t2 data after write", 64'(rd(0)), 64'h55);
    we = 1'b1; wa = 5'd7; wd = 32'h55AA; rsv = 1'b1; rsv_a = 5'd7;
    step();
    idle();
    #1;
    check("t2 same-cycle data", 64'(rd(1)), 64'h55AA);
    check("t2 same-cycle busy", 64'(rbusy[1]), 64'h1);

    // ---- Test 3: fill, sweep, dropped requests mid-sweep ----
    for (int i = 1; i < 32; i++) begin
      we = 1'b1; wa = AW'(i); wd = 32'(i);
      step();
    end
    idle();
    rsv = 1'b1; rsv_a = 5'd4;
    step();
    idle();
    set_rd(4, 31);
    #1;
    check("t3 r4 busy before sweep", 64'(rbusy[0]), 64'h1);
    check("t3 r31 before sweep", 64'(rd(1)), 64'd31);
    clr = 1'b1;
    step();
    idle();
    cnt = 0;
    while (cbusy === 1'b1 && cnt < 100) begin
      if (cnt == 5) begin
        set_rd(2, 20);
        #1;
        check("t3 mid-sweep r2 cleared", 64'(rd(0)), 64'h0);
        check("t3 mid-sweep r20 intact", 64'(rd(1)), 64'd20);
        we = 1'b1; wa = 5'd3; wd = 32'hFF;
      end
      if (cnt == 10) clr = 1'b1;
      if (cnt == 12) begin rsv = 1'b1; rsv_a = 5'd2; end
      step();
      idle();
      cnt++;
    end
    check("t3 sweep length", 64'(cnt), 64'd31);
    set_rd(3, 31);
    #1;
    check("t3 r3 after sweep", 64'(rd(0)), 64'h0);
    check("t3 r31 after sweep", 64'(rd(1)), 64'h0);
    set_rd(2, 4);
    #1;
    check("t3 busy r2/r4 after sweep", 64'(rbusy), 64'h0);
    we = 1'b1; wa = 5'd3; wd = 32'h77;
    step();
    idle();
    set_rd(3, 3);
    #1;
    check("t3 write accepted after sweep", 64'(rd(0)), 64'h77);

    // ---- Test 4: asynchronous reset mid-sweep ----
    we = 1'b1; wa = 5'd25; wd = 32'h2525; rsv = 1'b1; rsv_a = 5'd26;
    step();
    idle();
    clr = 1'b1;
    step();
    idle();
    repeat (9) step();
    set_rd(25, 26);
    #1;
    check("t4 r25 before reset", 64'(rd(0)), 64'h2525);
    check("t4 r26 busy before reset", 64'(rbusy[1]), 64'h1);
    check("t4 sweeping before reset", 64'(cbusy), 64'h1);
    #1 rst_ni = 1'b0;
    #1;
    check("t4 rd0 in reset", 64'(rd(0)), 64'h0);
    check("t4 busy in reset", 64'(rbusy), 64'h0);
    check("t4 clear_busy in reset", 64'(cbusy), 64'h0);
    #3 rst_ni = 1'b1;
    we = 1'b1; wa = 5'd20; wd = 32'h20;
    step();
    idle();
    set_rd(20, 20);
    #1;
    check("t4 write after reset", 64'(rd(0)), 64'h20);
    check("t4 idle after reset", 64'(cbusy), 64'h0);

    // ---- Test 5: same-cycle write/read of r9 ----
    set_rd(0, 9);
    we = 1'b1; wa = 5'd9; wd = 32'hCAFE;
    #1;
`ifdef RF_BYPASS_EN
    check("t5 bypass same cycle", 64'(rd(1)), 64'hCAFE);
`else
    check("t5 old value same cycle", 64'(rd(1)), 64'h0);
`endif
    step();
    idle();
    #1;
    check("t5 value next cycle", 64'(rd(1)), 64'hCAFE);
    set_rd(10, 10);
    we = 1'b1; wa = 5'd10; wd = 32'h1010; rsv = 1'b1; rsv_a = 5'd10;
    step();
    idle();

    // ---- Test 6: four ports, register 0 ordinary ----
    we4 = 1'b1; wa4 = 5'd0; wd4 = 32'hA;
    step();
    we4 = 1'b0;
    raddr4 = '0;
    #1;
    for (int k = 0; k < 4; k++)
      check($sformatf("t6 r0 port %0d", k), 64'(rdata4[k*DW +: DW]), 64'hA);
    rsv4 = 1'b1; rsv_a4 = 5'd0;
    step();
    rsv4 = 1'b0;
    #1;
    check("t6 r0 busy all ports", 64'(rbusy4), 64'hF);
    clr4 = 1'b1;
    step();
    clr4 = 1'b0;
    cnt = 0;
    while (cbusy4 === 1'b1 && cnt < 100) begin
      step();
      cnt++;
    end
    check("t6 sweep length", 64'(cnt), 64'd32);
    check("t6 r0 cleared", 64'(rdata4[DW-1:0]), 64'h0);
    check("t6 r0 busy cleared", 64'(rbusy4), 64'h0);

    step();
    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/rf_riscv_mp.md
Name: rf_riscv_mp

Overview:
Parametrised multi-read-port register file with an integrated per-register scoreboard and a sequential clear engine. It is the next-generation architectural register file for the pipelined core. It serves RD_PORTS combinational reads, one synchronous write, one reservation per cycle, and a multi-cycle sweep that zeroes every register. Register 0 reads as zero and ignores writes when ZERO_REG=1.

Parameters:
DATA_W, 32, register width in bits
ADDR_W, 5, address width; DEPTH = 2**ADDR_W registers
RD_PORTS, 2, number of independent read ports (1..4)
ZERO_REG, 1, 1 = register 0 hardwired to zero and never busy; 0 = register 0 is an ordinary register

Ports:
clk_i  input  1  clock, all state updates on rising edge
rst_ni  input  1  reset, asynchronous, active-low
write_enable_i  input  1  write strobe
write_addr_i  input  ADDR_W  write address
write_data_i  input  DATA_W  write data
read_addr_i  input  RD_PORTS*ADDR_W  packed read addresses; port k at bits [k*ADDR_W +: ADDR_W]
read_data_o  output  RD_PORTS*DATA_W  packed read data; port k at bits [k*DATA_W +: DATA_W]
read_busy_o  output  RD_PORTS  busy bit of each read port's addressed register
reserve_i  input  1  mark a register pending
reserve_addr_i  input  ADDR_W  register to reserve
clear_i  input  1  request a clear sweep (single-cycle pulse, level also accepted)
clear_busy_o  output  1  high while the sweep runs

Behaviour:
- Reset: while rst_ni=0, all registers are 0, all busy bits are 0, the FSM is IDLE, and the sweep counter is 0. Outputs therefore read 0, read_busy_o=0, clear_busy_o=0. Reset asserted mid-sweep aborts the sweep immediately.
- Reads: combinational, zero latency. read_data_o[k] = mem[read_addr k]. read_busy_o[k] = busy[read_addr k]. With ZERO_REG=1, address 0 returns 0 and busy 0 on every port.
- Write: when write_enable_i=1 in IDLE, mem[write_addr_i] <= write_data_i at the edge and busy[write_addr_i] is cleared. With ZERO_REG=1, a write to address 0 is dropped.
- Reserve: when reserve_i=1 in IDLE, busy[reserve_addr_i] <= 1. With ZERO_REG=1, reserving address 0 is ignored.
- Reserve and write to the same address in the same cycle: data is written and busy ends at 1 (the new reservation wins). For different addresses, both take effect.
- Reserving an already-busy register keeps it busy. Writing a non-busy register is legal.
- FSM states:
  - IDLE, with clear_i=1: go to SWEEP, set counter = ZERO_REG ? 1 : 0, clear_busy_o=1 from the next cycle. Writes and reserves presented in the same cycle as clear_i are still performed.
  - SWEEP: each cycle mem[counter] <= 0, busy[counter] <= 0, counter++. When counter = DEPTH-1 is cleared, return to IDLE and clear_busy_o drops the following cycle. The sweep lasts DEPTH-ZERO_REG cycles.
  - In SWEEP, write_enable_i, reserve_i and clear_i are ignored (dropped, not queued). Reads stay live and return the current contents, mixing cleared and uncleared registers.
- Counter is ADDR_W bits; wrap from DEPTH-1 never occurs, because the FSM exits first.
- No X propagation: all storage is reset.

Optional Feature:
RF_BYPASS_EN
- Defined: if write_enable_i is accepted (IDLE, non-dropped address) and write_addr_i equals read address k, then read_data_o[k] = write_data_i combinationally in the same cycle. read_busy_o[k] shows the post-edge value: 0, or 1 if a same-address reserve coincides.
- Not defined: reads return the stored (old) value until after the edge, and read_busy_o reflects current state only.

Test Plan:
1. Reset, then write 0xDEADBEEF to r5 and 0x1234 to r0; read r5 on port 0 and r0 on port 1 next cycle -> 0xDEADBEEF and 0x00000000.
2. Reserve r7; next cycle read_busy_o for r7 = 1. Write 0x55 to r7 -> busy 0, data 0x55. Reserve and write r7 in the same cycle -> data 0x55AA, busy 1.
3. Fill r1..r31 with their index, pulse clear_i -> clear_busy_o high for exactly 31 cycles. A write of 0xFF to r3 mid-sweep is dropped. All registers read 0 afterwards and write_enable_i is accepted again.
4. Start a sweep, deassert rst_ni asynchronously at cycle 10 -> all outputs 0 immediately, clear_busy_o=0. After release, a write to r20 succeeds on the first edge.
5. RF_BYPASS_EN defined: write 0xCAFE to r9 while port 1 reads r9 -> read_data_o port 1 = 0xCAFE in the same cycle. Without the macro, the old value 0 is returned and 0xCAFE appears next cycle.
6. RD_PORTS=4, ZERO_REG=0: write 0xA to r0, read r0 on all ports -> 0xA. Sweep length = 32 cycles.
